// File: rtl/shifter_pkg.sv
// Shared encodings and sizing helpers for the iterative shift/rotate unit.
// Op codes, FSM states and the width of the remaining-amount counter.
package shifter_pkg;

    typedef enum logic [2:0] {
        SHIFT_LEFT             = 3'd0,
        SHIFT_RIGHT_LOGICAL    = 3'd1,
        SHIFT_RIGHT_ARITHMETIC = 3'd2,
        ROTATE_LEFT            = 3'd3,
        ROTATE_RIGHT           = 3'd4
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must hold the value WIDTH itself (saturated shift amount).
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// One combinational step of the iterative shifter: shifts/rotates data_i by k_i bits,
// where k_i never exceeds STEP, so only STEP+1 fixed-distance candidates are built.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [2:0]       op_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] cand [STEP+1];

    for (genvar gi = 0; gi <= STEP; gi++) begin : g_amt
        logic [WIDTH-1:0] res;

        // The MSB of the working register is the original sign, so SRA stays correct per step.
        always_comb begin
            res = data_i;
            case (op_i)
                SHIFT_LEFT:             res = data_i << gi;
                SHIFT_RIGHT_LOGICAL:    res = data_i >> gi;
                SHIFT_RIGHT_ARITHMETIC: res = $signed(data_i) >>> gi;
                ROTATE_LEFT:            res = (data_i << gi) | (data_i >> (WIDTH - gi));
                ROTATE_RIGHT:           res = (data_i >> gi) | (data_i << (WIDTH - gi));
                default:                res = data_i;
            endcase
        end

        assign cand[gi] = res;
    end

    always_comb begin
        data_o = data_i;
        for (int j = 0; j <= STEP; j++) begin
            if (k_i == KW'(j)) begin
                data_o = cand[j];
            end
        end
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: accepts one request, shifts at most STEP bits per clock,
// then holds the result until the consumer takes it.
module iter_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [2:0]       shiftOp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam int LW = $clog2(WIDTH);
    localparam int KW = $clog2(STEP) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] out_q;
    logic             zero_q;
    logic [2:0]       op_q;
    logic [CW-1:0]    rem_q;
    logic [CW-1:0]    amt;
    logic [CW-1:0]    rem_after;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] step_res;
    logic             accept;

    assign accept = in_valid && (state_q == IDLE);

    // Effective amount: logical/arithmetic shifts saturate at WIDTH, rotates wrap.
    always_comb begin
        amt = '0;
        case (shiftOp)
            SHIFT_LEFT, SHIFT_RIGHT_LOGICAL, SHIFT_RIGHT_ARITHMETIC:
                amt = (inB >= WIDTH'(WIDTH)) ? CW'(WIDTH) : CW'(inB);
            ROTATE_LEFT, ROTATE_RIGHT:
                amt = CW'(inB[LW-1:0]);
            default:
                amt = '0;
        endcase
    end

    always_comb begin
        if (rem_q >= CW'(STEP)) begin
            k = KW'(STEP);
        end else begin
            k = KW'(rem_q);
        end
    end

    assign rem_after = rem_q - CW'(k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .k_i    (k),
        .data_o (step_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (amt == '0) ? DONE : BUSY;
            BUSY: if (rem_after == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == BUSY) || (state_q == DONE);
    end

    // The result registers change only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            op_q   <= '0;
            rem_q  <= '0;
            out_q  <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            data_q <= inA;
            op_q   <= shiftOp;
            rem_q  <= amt;
            if (amt == '0) begin
                out_q  <= inA;
                zero_q <= (inA == '0);
            end
        end else if (state_q == BUSY) begin
            data_q <= step_res;
            rem_q  <= rem_after;
            if (rem_after == '0) begin
                out_q  <= step_res;
                zero_q <= (step_res == '0);
            end
        end
    end

    assign out      = out_q;
    assign out_zero = zero_q;

endmodule
